// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential PC, 1-cycle ROM, 2-entry decode queue, halt/redirect.
// Define FETCH_CNT_EN to enable the delivered-instruction counter on fetch_cnt.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        irom_req,
    output logic [31:0] irom_adr,
    input  logic [31:0] irom_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_inst,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ent_pc_q   [2];
    logic [31:0] ent_pc_d   [2];
    logic [31:0] ent_inst_q [2];
    logic [31:0] ent_inst_d [2];

    logic [31:0] v_pc   [3];
    logic [31:0] v_inst [3];
    logic        resp;
    logic        pop;
    logic        issue;
    logic [2:0]  occ_next;
    logic        unused_rpc;

    assign unused_rpc = ^redirect_pc[1:0];

    // The returning response is appended behind the stored entries so it can be
    // presented the same cycle it arrives; a redirect suppresses it entirely.
    always_comb begin
        resp      = inflight_q & ~redirect_valid;
        v_pc[0]   = ent_pc_q[0];
        v_pc[1]   = ent_pc_q[1];
        v_pc[2]   = req_pc_q;
        v_inst[0] = ent_inst_q[0];
        v_inst[1] = ent_inst_q[1];
        v_inst[2] = irom_inst;
        if (resp && cnt_q == 2'd0) begin
            v_pc[0]   = req_pc_q;
            v_inst[0] = irom_inst;
        end else if (resp && cnt_q == 2'd1) begin
            v_pc[1]   = req_pc_q;
            v_inst[1] = irom_inst;
        end

        out_valid = (cnt_q != 2'd0) | resp;
        pop       = out_valid & out_ready;
        out_pc    = out_valid ? v_pc[0] : 32'h0;
        out_pc4   = out_valid ? v_pc[0] + 32'd4 : 32'h0;
        out_inst  = out_valid ? v_inst[0] : 32'h0;

        occ_next = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = (state_q == StRun) & ~redirect_valid & ~reset & (occ_next < 3'd2);
        irom_req = issue;
        irom_adr = fpc_q;

        for (int i = 0; i < 2; i++) begin
            ent_pc_d[i]   = pop ? v_pc[i+1] : v_pc[i];
            ent_inst_d[i] = pop ? v_inst[i+1] : v_inst[i];
        end
        cnt_d = redirect_valid ? 2'd0 : cnt_q + {1'b0, resp} - {1'b0, pop};

        inflight_d = issue;
        req_pc_d   = issue ? fpc_q : req_pc_q;
        fpc_d      = fpc_q;
        if (redirect_valid) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            fpc_d = fpc_q + 32'd4;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (halt) begin
                    state_d = inflight_q ? StDrain : StHalted;
                end
            end
            // ROM latency is fixed, so any outstanding response lands during DRAIN.
            StDrain:  state_d = halt ? StHalted : StRun;
            StHalted: state_d = halt ? StHalted : StRun;
            default:  state_d = StRun;
        endcase
        halted = (state_q == StHalted);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            fpc_q      <= RESET_PC;
            req_pc_q   <= 32'h0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]   <= 32'h0;
                ent_inst_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]   <= ent_pc_d[i];
                ent_inst_q[i] <= ent_inst_d[i];
            end
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'h0, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, backpressure, redirect, wrap, halt, counter.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        irom_req;
    logic [31:0] irom_adr;
    logic [31:0] irom_inst = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl #(
        .RESET_PC(32'h0000_0000)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .halted        (halted),
        .irom_req      (irom_req),
        .irom_adr      (irom_adr),
        .irom_inst     (irom_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_pc4       (out_pc4),
        .out_inst      (out_inst),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One-cycle synchronous ROM
    always @(posedge clk) begin
        if (irom_req) irom_inst <= rom(irom_adr);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cnt_exp;

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        out_ready      = 1'b1;

        // Reset values
        tick();
        tick();
        check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_req", {31'h0, irom_req}, 32'h0);
        check_eq("rst_halted", {31'h0, halted}, 32'h0);
        check_eq("rst_pc", out_pc, 32'h0);
        check_eq("rst_pc4", out_pc4, 32'h0);
        check_eq("rst_inst", out_inst, 32'h0);
        check_eq("rst_cnt", fetch_cnt, 32'h0);

        // Streaming with out_ready high
        reset = 1'b0;
        #1;
        check_eq("c0_req", {31'h0, irom_req}, 32'h1);
        check_eq("c0_adr", irom_adr, 32'h0);
        check_eq("c0_valid", {31'h0, out_valid}, 32'h0);
        tick();
        check_eq("c1_adr", irom_adr, 32'h4);
        check_eq("c1_valid", {31'h0, out_valid}, 32'h1);
        check_eq("c1_pc", out_pc, 32'h0);
        check_eq("c1_pc4", out_pc4, 32'h4);
        check_eq("c1_inst", out_inst, rom(32'h0));
        tick();
        check_eq("c2_adr", irom_adr, 32'h8);
        check_eq("c2_pc", out_pc, 32'h4);
        check_eq("c2_pc4", out_pc4, 32'h8);

        // Backpressure: hold ready low for cycles 0..4
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("bp0_adr", irom_adr, 32'h0);
        check_eq("bp0_req", {31'h0, irom_req}, 32'h1);
        tick();
        check_eq("bp1_adr", irom_adr, 32'h4);
        check_eq("bp1_req", {31'h0, irom_req}, 32'h1);
        check_eq("bp1_pc", out_pc, 32'h0);
        for (int i = 2; i < 5; i++) begin
            tick();
            check_eq("bp_full_req", {31'h0, irom_req}, 32'h0);
            check_eq("bp_full_valid", {31'h0, out_valid}, 32'h1);
            check_eq("bp_full_pc", out_pc, 32'h0);
            check_eq("bp_full_inst", out_inst, rom(32'h0));
        end
        tick();
        out_ready = 1'b1;
        #1;
        check_eq("bp5_pc", out_pc, 32'h0);
        check_eq("bp5_adr", irom_adr, 32'h8);
        check_eq("bp5_req", {31'h0, irom_req}, 32'h1);
        tick();
        check_eq("bp6_pc", out_pc, 32'h4);
        check_eq("bp6_inst", out_inst, rom(32'h4));
        check_eq("bp6_adr", irom_adr, 32'hC);
        tick();
        check_eq("bp7_pc", out_pc, 32'h8);

        // Redirect while request for 0x10 is in flight
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        check_eq("rd_req", {31'h0, irom_req}, 32'h0);
        check_eq("rd_pc", out_pc, 32'hC);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("rd1_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rd1_adr", irom_adr, 32'h100);
        check_eq("rd1_req", {31'h0, irom_req}, 32'h1);
        tick();
        check_eq("rd2_pc", out_pc, 32'h100);
        check_eq("rd2_pc4", out_pc4, 32'h104);
        check_eq("rd2_inst", out_inst, rom(32'h100));

        // PC wrap at the top of the address space
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        check_eq("wr_valid", {31'h0, out_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("wr1_adr", irom_adr, 32'hFFFF_FFFC);
        tick();
        check_eq("wr2_pc", out_pc, 32'hFFFF_FFFC);
        check_eq("wr2_pc4", out_pc4, 32'h0);
        check_eq("wr2_adr", irom_adr, 32'h0);
        tick();
        check_eq("wr3_pc", out_pc, 32'h0);
        check_eq("wr3_pc4", out_pc4, 32'h4);

        // Halt with a request in flight
        tick();
        halt = 1'b1;
        #1;
        check_eq("h0_halted", {31'h0, halted}, 32'h0);
        check_eq("h0_pc", out_pc, 32'h4);
        tick();
        check_eq("h1_halted", {31'h0, halted}, 32'h0);
        check_eq("h1_req", {31'h0, irom_req}, 32'h0);
        check_eq("h1_pc", out_pc, 32'h8);
        tick();
        check_eq("h2_halted", {31'h0, halted}, 32'h1);
        check_eq("h2_req", {31'h0, irom_req}, 32'h0);
        check_eq("h2_valid", {31'h0, out_valid}, 32'h0);
        tick();
        halt = 1'b0;
        #1;
        check_eq("h3_halted", {31'h0, halted}, 32'h1);
        check_eq("h3_req", {31'h0, irom_req}, 32'h0);
        tick();
        check_eq("h4_halted", {31'h0, halted}, 32'h0);
        check_eq("h4_req", {31'h0, irom_req}, 32'h1);
        check_eq("h4_adr", irom_adr, 32'hC);
        tick();
        check_eq("h5_pc", out_pc, 32'hC);

        // Counter: 10 handshakes, then asynchronous reset mid-fetch
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        for (int i = 1; i <= 10; i++) tick();
        tick();
        out_ready = 1'b0;
        #1;
`ifdef FETCH_CNT_EN
        cnt_exp = 32'd10;
`else
        cnt_exp = 32'd0;
`endif
        check_eq("cnt_10", fetch_cnt, cnt_exp);
        #1;
        reset = 1'b1;
        #1;
        check_eq("cnt_rst", fetch_cnt, 32'h0);
        check_eq("arst_valid", {31'h0, out_valid}, 32'h0);
        check_eq("arst_req", {31'h0, irom_req}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_eq("post_valid", {31'h0, out_valid}, 32'h0);
        check_eq("post_adr", irom_adr, 32'h0);
        tick();
        check_eq("post_pc", out_pc, 32'h0);
        check_eq("post_inst", out_inst, rom(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
